// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock time-setting logic.
// Holds the controller state encodings, display blank bit positions and small
// decode helpers used by the set controller.
package clock_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  // Bit positions inside the {hr,min,sec} blank mask
  localparam int BLANK_SEC = 0;
  localparam int BLANK_MIN = 1;
  localparam int BLANK_HR  = 2;

  // One-hot mask of the field edited in a given state (zero in RUN)
  function automatic logic [2:0] field_mask(input mode_t m);
    logic [2:0] mask;
    mask = 3'b000;
    case (m)
      SET_HR:  mask[BLANK_HR]  = 1'b1;
      SET_MIN: mask[BLANK_MIN] = 1'b1;
      SET_SEC: mask[BLANK_SEC] = 1'b1;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  // Mode button advances RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      RUN:     n = SET_HR;
      SET_HR:  n = SET_MIN;
      SET_MIN: n = SET_SEC;
      default: n = RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_pulse.sv
// Button edge detector with optional hold-to-repeat.
// Auto-repeat is built only when CLOCK_SET_AUTOREPEAT_EN is defined; otherwise
// rpt is tied low and the repeat parameters have no effect.
// The repeat counter assumes REPEAT_CYCLES <= HOLD_CYCLES.
module key_pulse #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic srst,
  input  logic btn,
  input  logic allow,
  input  logic clear,
  output logic press,
  output logic rpt
);

  logic prev_reg;

  // Previous button level; reset high so a button held through reset is not an edge
  always_ff @(posedge clk) begin
    if (srst) prev_reg <= 1'b1;
    else      prev_reg <= btn;
  end

  assign press = btn & ~prev_reg;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] rpt_cnt_reg;
  logic          held;

  // Held means still pressed after the edge cycle, in a field that allows repeat
  assign held = btn & prev_reg & allow;
  assign rpt  = held & (rpt_cnt_reg == CW'(HOLD_CYCLES - 1));

  // Counts held cycles; after a repeat it reloads so the next one is REPEAT_CYCLES away
  always_ff @(posedge clk) begin
    if (srst || !held || clear) rpt_cnt_reg <= '0;
    else if (rpt)               rpt_cnt_reg <= CW'(HOLD_CYCLES - REPEAT_CYCLES);
    else                        rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
  end
`else
  logic unused_cfg;

  assign rpt        = 1'b0;
  assign unused_cfg = allow ^ clear ^ (HOLD_CYCLES > 0) ^ (REPEAT_CYCLES > 0);
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting and run-mode controller for the digital clock.
// Turns debounced mode/inc buttons into field count enables, manual increment
// and clear pulses, an idle timeout back to RUN and the display blink mask.
// Optional hold-to-repeat on inc is enabled by CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S     = 10,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic              CP,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              sec_max,
  input  logic              min_max,
  output logic              sec_en,
  output logic              min_en,
  output logic              hr_en,
  output logic              min_inc,
  output logic              hr_inc,
  output logic              sec_clr,
  output logic [MODE_W-1:0] mode,
  output logic [2:0]        blank
);

  localparam int IW = $clog2(TIMEOUT_S + 1);

  mode_t         state_reg;
  logic [IW-1:0] idle_reg;
  logic          blink_ph;
  logic          mode_edge;
  logic          mode_rpt;
  logic          inc_edge;
  logic          inc_rpt;
  logic          inc_pulse;
  logic          rpt_allow;
  logic          expire;

  assign rpt_allow = (state_reg == SET_HR) || (state_reg == SET_MIN);
  assign inc_pulse = inc_edge | inc_rpt;
  assign expire    = (idle_reg == IW'(TIMEOUT_S));
  assign mode      = state_reg;

  key_pulse #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_mode_key (
    .clk   (CP),
    .srst  (reset),
    .btn   (btn_mode),
    .allow (1'b0),
    .clear (1'b0),
    .press (mode_edge),
    .rpt   (mode_rpt)
  );

  key_pulse #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_inc_key (
    .clk   (CP),
    .srst  (reset),
    .btn   (btn_inc),
    .allow (rpt_allow),
    .clear (mode_edge),
    .press (inc_edge),
    .rpt   (inc_rpt)
  );

  logic unused_mode_rpt;
  assign unused_mode_rpt = mode_rpt;

  // Mode FSM with registered enables, pulses, idle timeout and blink mask
  always_ff @(posedge CP) begin
    if (reset) begin
      state_reg <= RUN;
      idle_reg  <= '0;
      blink_ph  <= 1'b0;
      sec_en    <= 1'b0;
      min_en    <= 1'b0;
      hr_en     <= 1'b0;
      min_inc   <= 1'b0;
      hr_inc    <= 1'b0;
      sec_clr   <= 1'b0;
      blank     <= 3'b000;
    end else begin
      sec_en  <= 1'b0;
      min_en  <= 1'b0;
      hr_en   <= 1'b0;
      min_inc <= 1'b0;
      hr_inc  <= 1'b0;
      sec_clr <= 1'b0;
      if (state_reg == RUN) begin
        // Normal running: cascade enables, inc ignored
        sec_en   <= tick_1hz;
        min_en   <= tick_1hz & sec_max;
        hr_en    <= tick_1hz & sec_max & min_max;
        idle_reg <= '0;
        blink_ph <= 1'b0;
        blank    <= 3'b000;
        if (mode_edge) state_reg <= SET_HR;
      end else if (mode_edge) begin
        // Mode wins over a same-cycle inc edge and over timeout expiry
        state_reg <= next_mode(state_reg);
        idle_reg  <= '0;
        blink_ph  <= 1'b0;
        blank     <= 3'b000;
      end else if (!inc_pulse && expire) begin
        state_reg <= RUN;
        idle_reg  <= '0;
        blink_ph  <= 1'b0;
        blank     <= 3'b000;
      end else begin
        if (inc_pulse) begin
          idle_reg <= '0;
          case (state_reg)
            SET_HR:  hr_inc  <= 1'b1;
            SET_MIN: min_inc <= 1'b1;
            SET_SEC: sec_clr <= 1'b1;
            default: ;
          endcase
        end else if (tick_1hz) begin
          idle_reg <= idle_reg + 1'b1;
        end
        if (tick_1hz) begin
          blink_ph <= ~blink_ph;
          blank    <= blink_ph ? 3'b000 : field_mask(state_reg);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with directed vectors.
// Runs with TIMEOUT_S=3, HOLD_CYCLES=8, REPEAT_CYCLES=4; expectations for the
// hold-to-repeat test follow CLOCK_SET_AUTOREPEAT_EN when it is defined.
module tb_clock_set_ctrl;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic       CP;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_max;
  logic       min_max;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       min_inc;
  logic       hr_inc;
  logic       sec_clr;
  logic [1:0] mode;
  logic [2:0] blank;

  int vectors;
  int miscompares;

  clock_set_ctrl #(
    .TIMEOUT_S     (3),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .CP       (CP),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_max  (sec_max),
    .min_max  (min_max),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hr_en    (hr_en),
    .min_inc  (min_inc),
    .hr_inc   (hr_inc),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .blank    (blank)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Advance one clock; outputs are stable 1 ns after the edge
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    $display("test_reset: mode held through reset, then fresh press");
    reset = 1'b1; btn_mode = 1'b1; btn_inc = 1'b0;
    step(); step();
    outs = {sec_en, min_en, hr_en, min_inc, hr_inc, sec_clr, blank, mode, 1'b0};
    vectors++;
    if (outs !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", outs, 12'd0);
    end
    reset = 1'b0;
    step(); step();
    vectors++;
    if (mode !== 2'd0) begin
      miscompares++;
      $display("FAIL held_no_edge: mode got %0d want 0", mode);
    end
    btn_mode = 1'b0; step();
    vectors++;
    if (mode !== 2'd0) begin
      miscompares++;
      $display("FAIL release_no_edge: mode got %0d want 0", mode);
    end
    btn_mode = 1'b1; step();
    vectors++;
    if (mode !== 2'd1) begin
      miscompares++;
      $display("FAIL fresh_press: mode got %0d want 1", mode);
    end
    btn_mode = 1'b0; step();
    // Reset while in SET_HR with an inc edge pending: RUN, no pulse
    reset = 1'b1; btn_inc = 1'b1; step();
    vectors++;
    if (mode !== 2'd0 || hr_inc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_set: mode %0d hr_inc %b want mode 0 hr_inc 0", mode, hr_inc);
    end
    reset = 1'b0; btn_inc = 1'b0; step(); step();
  endtask

  task automatic test_run_enables();
    logic [2:0] en;
    logic [2:0] exp_en [3];
    logic [1:0] maxes  [3];
    $display("test_run_enables: cascade enables in RUN");
    maxes[0] = 2'b11; exp_en[0] = 3'b111;
    maxes[1] = 2'b10; exp_en[1] = 3'b110;
    maxes[2] = 2'b01; exp_en[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      {sec_max, min_max} = maxes[i];
      tick_1hz = 1'b0; step();
      en = {sec_en, min_en, hr_en};
      vectors++;
      if (en !== 3'b000) begin
        miscompares++;
        $display("FAIL run_no_tick[%0d]: en got %b want 000", i, en);
      end
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0;
      en = {sec_en, min_en, hr_en};
      vectors++;
      if (en !== exp_en[i]) begin
        miscompares++;
        $display("FAIL run_tick[%0d]: en got %b want %b", i, en, exp_en[i]);
      end
      step();
      en = {sec_en, min_en, hr_en};
      vectors++;
      if (en !== 3'b000) begin
        miscompares++;
        $display("FAIL run_one_cycle[%0d]: en got %b want 000", i, en);
      end
    end
    sec_max = 1'b0; min_max = 1'b0;
  endtask

  task automatic test_set_sequence();
    logic [1:0] exp_mode [4];
    logic [2:0] pulses;
    logic [2:0] exp_p;
    $display("test_set_sequence: four mode presses with an inc press in each SET state");
    exp_mode[0] = 2'd1; exp_mode[1] = 2'd2; exp_mode[2] = 2'd3; exp_mode[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      btn_mode = 1'b1; step();
      btn_mode = 1'b0;
      vectors++;
      if (mode !== exp_mode[i] || blank !== 3'b000) begin
        miscompares++;
        $display("FAIL mode_seq[%0d]: mode %0d blank %b want mode %0d blank 000",
                 i, mode, blank, exp_mode[i]);
      end
      step();
      if (i < 3) begin
        btn_inc = 1'b1; step();
        btn_inc = 1'b0;
        pulses = {hr_inc, min_inc, sec_clr};
        exp_p  = 3'b100 >> i;
        vectors++;
        if (pulses !== exp_p || {sec_en, min_en, hr_en} !== 3'b000) begin
          miscompares++;
          $display("FAIL set_pulse[%0d]: hr/min/sec %b en %b want %b en 000",
                   i, pulses, {sec_en, min_en, hr_en}, exp_p);
        end
        step();
        pulses = {hr_inc, min_inc, sec_clr};
        vectors++;
        if (pulses !== 3'b000) begin
          miscompares++;
          $display("FAIL pulse_width[%0d]: got %b want 000", i, pulses);
        end
        if (i == 1) begin
          // Tick in SET_MIN: clock frozen, minutes field starts blinking
          sec_max = 1'b1; min_max = 1'b1; tick_1hz = 1'b1; step();
          tick_1hz = 1'b0; sec_max = 1'b0; min_max = 1'b0;
          vectors++;
          if ({sec_en, min_en, hr_en} !== 3'b000 || blank !== 3'b010) begin
            miscompares++;
            $display("FAIL set_frozen_blink: en %b blank %b want en 000 blank 010",
                     {sec_en, min_en, hr_en}, blank);
          end
          step();
        end
      end
    end
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
  endtask

  task automatic test_timeout();
    $display("test_timeout: idle return to RUN from SET_MIN");
    for (int i = 0; i < 2; i++) begin
      btn_mode = 1'b1; step();
      btn_mode = 1'b0; step();
    end
    tick_once(); tick_once();
    btn_inc = 1'b1; step();
    btn_inc = 1'b0;
    vectors++;
    if (min_inc !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_inc: min_inc got %b want 1", min_inc);
    end
    step();
    tick_once(); tick_once();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0;
    // Idle now at limit; an inc edge this cycle wins over expiry
    btn_inc = 1'b1; step();
    btn_inc = 1'b0;
    vectors++;
    if (mode !== 2'd2 || min_inc !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_beats_expiry: mode %0d min_inc %b want mode 2 min_inc 1", mode, min_inc);
    end
    step();
    tick_once(); tick_once();
    vectors++;
    if (mode !== 2'd2) begin
      miscompares++;
      $display("FAIL before_third_tick: mode got %0d want 2", mode);
    end
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0;
    vectors++;
    if (mode !== 2'd2) begin
      miscompares++;
      $display("FAIL at_third_tick: mode got %0d want 2", mode);
    end
    step();
    vectors++;
    if (mode !== 2'd0 || blank !== 3'b000) begin
      miscompares++;
      $display("FAIL timeout_run: mode %0d blank %b want mode 0 blank 000", mode, blank);
    end
    step();
  endtask

  task automatic test_simultaneous();
    $display("test_simultaneous: mode+inc and mode+expiry in the same cycle");
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
    btn_mode = 1'b1; btn_inc = 1'b1; step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    vectors++;
    if (mode !== 2'd2 || hr_inc !== 1'b0 || min_inc !== 1'b0) begin
      miscompares++;
      $display("FAIL mode_beats_inc: mode %0d hr_inc %b min_inc %b want 2 0 0", mode, hr_inc, min_inc);
    end
    step();
    vectors++;
    if (hr_inc !== 1'b0 || min_inc !== 1'b0) begin
      miscompares++;
      $display("FAIL dropped_inc: hr_inc %b min_inc %b want 0 0", hr_inc, min_inc);
    end
    tick_once(); tick_once();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0;
    btn_mode = 1'b1; step();
    btn_mode = 1'b0;
    vectors++;
    if (mode !== 2'd3) begin
      miscompares++;
      $display("FAIL mode_at_expiry: mode got %0d want 3", mode);
    end
    step();
    vectors++;
    if (mode !== 2'd3) begin
      miscompares++;
      $display("FAIL single_transition: mode got %0d want 3", mode);
    end
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic test_autorepeat();
    logic exp_p;
    $display("test_autorepeat: inc held in SET_HR, autorepeat=%0d", AUTOREPEAT);
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
    btn_inc = 1'b1;
    // j = 0 is the press edge; repeats expected at j = 8, 12, 16, 20
    for (int j = 0; j <= 20; j++) begin
      step();
      exp_p = (j == 0) || (AUTOREPEAT && (j == 8 || j == 12 || j == 16 || j == 20));
      vectors++;
      if (hr_inc !== exp_p) begin
        miscompares++;
        $display("FAIL hold_pulse[%0d]: hr_inc got %b want %b", j, hr_inc, exp_p);
      end
    end
    btn_inc = 1'b0; step();
    vectors++;
    if (hr_inc !== 1'b0 || mode !== 2'd1) begin
      miscompares++;
      $display("FAIL after_release: hr_inc %b mode %0d want 0 1", hr_inc, mode);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    sec_max = 1'b0; min_max = 1'b0;
    test_reset();
    test_run_enables();
    test_set_sequence();
    test_timeout();
    test_simultaneous();
    test_autorepeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting and run-mode controller for the digital clock. It converts the debounced `mode` and `inc` buttons into per-field count enables and single-cycle increment or clear pulses for the hour, minute and second counter pairs. It also produces the display blink mask. It sits between the button debouncers and the counter chain, and owns the cascade enables in normal running.

## Interface

Parameters:
- `TIMEOUT_S`, default 10: seconds of button inactivity in a SET state before forced return to RUN.
- `HOLD_CYCLES`, default 25_000_000: CP cycles `inc` must be held before auto-repeat starts.
- `REPEAT_CYCLES`, default 5_000_000: CP cycles between auto-repeat pulses.

Ports:
- `CP`, input, 1: system clock, rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `tick_1hz`, input, 1: one-cycle strobe, once per second.
- `btn_mode`, input, 1: debounced mode button level, high = pressed.
- `btn_inc`, input, 1: debounced increment button level, high = pressed.
- `sec_max`, input, 1: seconds field currently reads 59.
- `min_max`, input, 1: minutes field currently reads 59.
- `sec_en`, `min_en`, `hr_en`, output, 1 each: count enables to the field counter pairs.
- `min_inc`, `hr_inc`, output, 1 each: single-cycle manual increment pulses.
- `sec_clr`, output, 1: single-cycle clear of the seconds field.
- `mode`, output, 2: current state encoding.
- `blank`, output, 3: `{hr,min,sec}` display blank mask.

## Operation

- States:
  - RUN = 0, SET_HR = 1, SET_MIN = 2, SET_SEC = 3.
  - A `mode` rising edge advances RUN → SET_HR → SET_MIN → SET_SEC → RUN.
- Edge detection: `*_prev` registers sample the buttons every cycle. Edge = level high and prev low.
- RUN:
  - `sec_en` = `tick_1hz`.
  - `min_en` = `tick_1hz & sec_max`.
  - `hr_en` = `tick_1hz & sec_max & min_max`.
  - `inc` edges are ignored.
- SET states:
  - All `*_en` are held low, so the clock is frozen.
  - An `inc` edge pulses the field's output: `hr_inc` in SET_HR, `min_inc` in SET_MIN, `sec_clr` in SET_SEC.
  - Field wrap (hour 23→0, minute 59→0) is done by the counters, not here.
- Idle timeout:
  - The idle counter has width clog2(TIMEOUT_S+1).
  - It clears on entering any SET state and on any button edge or repeat pulse.
  - It increments on `tick_1hz` in SET states.
  - On reaching TIMEOUT_S it forces RUN at the next edge.
- Blink:
  - `blink_ph` toggles on `tick_1hz` in SET states and clears on every state change.
  - `blank` = one-hot mask of the field being set when `blink_ph`=1, otherwise 0. It is always 0 in RUN.
- Simultaneous events:
  - `mode` and `inc` edges in the same cycle: mode wins and the inc edge is dropped.
  - A button edge and timeout expiry in the same cycle: the edge wins and the counter clears.
  - A `mode` edge and timeout expiry in the same cycle: exactly one transition, to the next state per `mode`.

## Timing

- All outputs are registered.
- Latency: an edge detected at CP edge k is visible on `*_inc`/`sec_clr`/`mode` after edge k. Each pulse is exactly one cycle wide.
- Run enables lag `tick_1hz` by one cycle. `sec_max`/`min_max` are sampled in the same cycle as the tick.
- Reset values:
  - `mode` = RUN, all enables/pulses = 0, `blank` = 0.
  - Idle counter, repeat counter and `blink_ph` = 0.
  - `*_prev` = 1, so a button held through reset produces no edge.
- Reset asserted mid-SET: RUN on the next edge; no pulse is emitted in that cycle.

## Configuration

- Macro: `CLOCK_SET_AUTOREPEAT_EN`.
- Defined:
  - In SET_HR/SET_MIN, holding `btn_inc` continuously for HOLD_CYCLES after the edge emits one extra pulse.
  - It then emits a pulse every REPEAT_CYCLES until release.
  - Release or a state change clears the repeat counter.
  - Auto-repeat never applies in SET_SEC.
- Undefined: one pulse per press only; the repeat counter and its parameters are unused.

## Structure

- Shared package `clock_pkg`: state encodings RUN/SET_HR/SET_MIN/SET_SEC, the `blank` bit indices, and the mode width constant.
- Sub-module `key_pulse`: edge detect plus optional auto-repeat counter. One instance each for `mode` (repeat disabled) and `inc`. The FSM, enables, timeout and blink logic stay in the top module.

## Test plan

- Reset with `btn_mode`=1 held, then release, then press: no edge while held; `mode` goes 0→1 only after the fresh press.
- RUN with `sec_max`=1, `min_max`=1, `tick_1hz` pulse: `sec_en`, `min_en` and `hr_en` all high for exactly one cycle, one cycle after the tick.
- Four `mode` presses, with an `inc` press in each state:
  - `mode` sequence 1,2,3,0.
  - Exactly one `hr_inc`, one `min_inc` and one `sec_clr`; `*_en` stays 0 throughout SET.
- `TIMEOUT_S`=3 in SET_MIN, no presses, three ticks: `mode` returns to 0 after the third tick; an `inc` press between ticks restarts the count.
- `mode` and `inc` rising in the same cycle in SET_HR: `mode`=2 and no `hr_inc` pulse.
- `CLOCK_SET_AUTOREPEAT_EN`, HOLD_CYCLES=8, REPEAT_CYCLES=4, `inc` held 20 cycles in SET_HR: `hr_inc` pulses at press+1, +9, +13, +17 and +21. Without the macro: a single pulse.
